// File: rtl/line_buf_reader_if.sv
// Pixel stream from the line buffer reader to the display.
// Master drives pixel and markers, slave drives ready.
interface line_buf_reader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_eol;
  logic              pix_eoh;

  modport master (
    output pix_data, pix_valid, pix_eol, pix_eoh,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_eol, pix_eoh,
    output pix_ready
  );
endinterface

// File: rtl/line_buf_reader.sv
// Ping-pong line buffer reader: streams a filled half
// to the display and hands it back to the writer.
module line_buf_reader #(
  parameter int PIX_PER_LINE   = 240,
  parameter int LINES_PER_HALF = 4,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        half_ready,
  output logic [1:0]        half_done,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rdata,
  line_buf_reader_if.master pix,
  output logic              busy,
  output logic              ovf_err
);

  localparam int HALF_WORDS = PIX_PER_LINE * LINES_PER_HALF;
  localparam int CNT_W  = $clog2(HALF_WORDS + 1);
  localparam int COL_W  = $clog2(PIX_PER_LINE);
  localparam int LINE_W = (LINES_PER_HALF > 1) ?
                          $clog2(LINES_PER_HALF) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic              next_half;
  logic [1:0]        pend;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] last_addr;
  logic [CNT_W-1:0]  rd_cnt;
  logic              inflight;
  logic [1:0]        fcnt;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;

  logic              pop;
  logic              issue;
  logic              start;
  logic [1:0]        clr;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] base;

  assign pix.pix_valid = (fcnt != 2'd0);
  assign pix.pix_data  = q0;
  assign pix.pix_eol   = pix.pix_valid &
                         (col == COL_W'(PIX_PER_LINE - 1));
  assign pix.pix_eoh   = pix.pix_eol &
                         (line == LINE_W'(LINES_PER_HALF - 1));

  assign pop   = pix.pix_valid & pix.pix_ready;
  // occupancy the FIFO will see once in-flight data lands
  assign occ   = {1'b0, fcnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == STREAM) & (occ < 3'd2);

  assign ram_rd_en = issue;
  assign ram_raddr = issue ? rd_ptr : last_addr;

  assign base  = next_half ? ADDR_W'(HALF_WORDS) : '0;
  assign start = (state == IDLE) & pend[next_half];
  assign clr   = start ? (next_half ? 2'b10 : 2'b01) : 2'b00;
  assign busy  = (state != IDLE);

  // pending halves; a new announce beats the start-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      ovf_err <= 1'b0;
    end else begin
      pend    <= (pend & ~clr) | half_ready;
      ovf_err <= ovf_err | (|(half_ready & pend));
    end
  end

  // half sequencing and read address generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      next_half <= 1'b0;
      rd_ptr    <= '0;
      last_addr <= '0;
      rd_cnt    <= '0;
      half_done <= '0;
    end else begin
      half_done <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= STREAM;
            rd_ptr <= base;
            rd_cnt <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            last_addr <= rd_ptr;
            rd_ptr    <= rd_ptr + 1'b1;
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_cnt == CNT_W'(HALF_WORDS - 1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight &&
              (fcnt == 2'd0 || (fcnt == 2'd1 && pop))) begin
            state     <= DONE;
            half_done <= next_half ? 2'b10 : 2'b01;
          end
        end
        DONE: begin
          next_half <= ~next_half;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 2-entry output FIFO, head entry drives the pixel bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      fcnt     <= '0;
      q0       <= '0;
      q1       <= '0;
    end else begin
      inflight <= issue;
      case ({inflight, pop})
        2'b10: begin
          if (fcnt == 2'd0) q0 <= ram_rdata;
          else              q1 <= ram_rdata;
          fcnt <= fcnt + 2'd1;
        end
        2'b01: begin
          q0   <= q1;
          fcnt <= fcnt - 2'd1;
        end
        2'b11: begin
          if (fcnt == 2'd1) begin
            q0 <= ram_rdata;
          end else begin
            q0 <= q1;
            q1 <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // column/line position of the head pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
    end else if (state == DONE) begin
      col  <= '0;
      line <= '0;
    end else if (pop) begin
      if (col == COL_W'(PIX_PER_LINE - 1)) begin
        col  <= '0;
        line <= (line == LINE_W'(LINES_PER_HALF - 1)) ?
                '0 : line + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_buf_reader.sv
// Testbench for line_buf_reader: table-checked latency trace
// plus scoreboarded streams under random back-pressure.
module tb_line_buf_reader;

  localparam int HW = 960;
  localparam int NREC = 971;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  half_ready;
  logic [1:0]  half_done;
  logic [11:0] ram_raddr;
  logic        ram_rd_en;
  logic [15:0] ram_rdata = '0;
  logic        busy;
  logic        ovf_err;
  logic        rand_ready = 1'b0;

  line_buf_reader_if #(.DATA_W(16)) pix ();

  line_buf_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .half_ready (half_ready),
    .half_done  (half_done),
    .ram_raddr  (ram_raddr),
    .ram_rd_en  (ram_rd_en),
    .ram_rdata  (ram_rdata),
    .pix        (pix),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];

  always @(posedge clk)
    if (ram_rd_en) ram_rdata <= mem[ram_raddr];

  always @(posedge clk) begin
    #1;
    pix.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        eol;
    logic        eoh;
  } pix_t;

  pix_t exp_q[$];

  task automatic push_half(int h);
    pix_t p;
    for (int k = 0; k < HW; k++) begin
      p.d   = mem[h * HW + k];
      p.eol = ((k % 240) == 239);
      p.eoh = (k == HW - 1);
      exp_q.push_back(p);
    end
  endtask

  int issued = 0;
  int popped = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_d;
  logic        prev_eol;
  logic        prev_eoh;

  always @(negedge clk) begin
    pix_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", int'(pix.pix_valid), 1);
        check("stall_data", int'(pix.pix_data), int'(prev_d));
        check("stall_eol", int'(pix.pix_eol), int'(prev_eol));
        check("stall_eoh", int'(pix.pix_eoh), int'(prev_eoh));
      end
      if (pix.pix_valid && pix.pix_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check("unexpected_pix", int'(pix.pix_data), -1);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", int'(pix.pix_data), int'(e.d));
          check("pix_eol", int'(pix.pix_eol), int'(e.eol));
          check("pix_eoh", int'(pix.pix_eoh), int'(e.eoh));
        end
      end
      if (ram_rd_en) begin
        issued++;
        check("outstanding_le2", int'((issued - popped) <= 2), 1);
      end
      stall_prev = pix.pix_valid & ~pix.pix_ready;
      prev_d   = pix.pix_data;
      prev_eol = pix.pix_eol;
      prev_eoh = pix.pix_eoh;
    end
  end

  task automatic pulse(logic [1:0] v);
    @(posedge clk); #1 half_ready = v;
    @(posedge clk); #1 half_ready = 2'b00;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_rd_en"}, int'(ram_rd_en), 0);
    check({tag, "_raddr"}, int'(ram_raddr), 0);
    check({tag, "_valid"}, int'(pix.pix_valid), 0);
    check({tag, "_data"}, int'(pix.pix_data), 0);
    check({tag, "_eol"}, int'(pix.pix_eol), 0);
    check({tag, "_eoh"}, int'(pix.pix_eoh), 0);
    check({tag, "_done"}, int'(half_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ovf"}, int'(ovf_err), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(logic [1:0] exp, int budget);
    int n;
    n = 0;
    while (half_done == 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("half_done", int'(half_done), int'(exp));
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic wait_empty(int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("stream_complete_left", exp_q.size(), 0);
  endtask

  typedef struct {
    int n;
    int rd_en;
    int raddr;
    int valid;
    int data;
    int eol;
    int eoh;
    int done;
    int busy;
  } vec_t;

  vec_t vt[14];

  logic        r_rd_en [NREC];
  logic [11:0] r_raddr [NREC];
  logic        r_valid [NREC];
  logic [15:0] r_data  [NREC];
  logic        r_eol   [NREC];
  logic        r_eoh   [NREC];
  logic [1:0]  r_done  [NREC];
  logic        r_busy  [NREC];

  initial begin
    int p0;
    int n;
    vt[0]  = '{0,   0, 0,   0, 0,   0, 0, 0, 0};
    vt[1]  = '{1,   0, 0,   0, 0,   0, 0, 0, 0};
    vt[2]  = '{2,   1, 0,   0, 0,   0, 0, 0, 1};
    vt[3]  = '{3,   1, 1,   0, 0,   0, 0, 0, 1};
    vt[4]  = '{4,   1, 2,   1, 0,   0, 0, 0, 1};
    vt[5]  = '{243, 1, 241, 1, 239, 1, 0, 0, 1};
    vt[6]  = '{244, 1, 242, 1, 240, 0, 0, 0, 1};
    vt[7]  = '{483, 1, 481, 1, 479, 1, 0, 0, 1};
    vt[8]  = '{723, 1, 721, 1, 719, 1, 0, 0, 1};
    vt[9]  = '{961, 1, 959, 1, 957, 0, 0, 0, 1};
    vt[10] = '{962, 0, 959, 1, 958, 0, 0, 0, 1};
    vt[11] = '{963, 0, 959, 1, 959, 1, 1, 0, 1};
    vt[12] = '{964, 0, 959, 0, 0,   0, 0, 1, 1};
    vt[13] = '{965, 0, 959, 0, 0,   0, 0, 0, 0};

    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    half_ready    = 2'b00;
    pix.pix_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single half, full speed, cycle-accurate trace
    push_half(0);
    @(posedge clk); #1 half_ready = 2'b01;
    for (int k = 0; k < NREC; k++) begin
      @(negedge clk);
      r_rd_en[k] = ram_rd_en;
      r_raddr[k] = ram_raddr;
      r_valid[k] = pix.pix_valid;
      r_data[k]  = pix.pix_data;
      r_eol[k]   = pix.pix_eol;
      r_eoh[k]   = pix.pix_eoh;
      r_done[k]  = half_done;
      r_busy[k]  = busy;
      @(posedge clk); #1 half_ready = 2'b00;
    end
    for (int i = 0; i < $size(vt); i++) begin
      n = vt[i].n;
      check($sformatf("t%0d_rd_en", n), int'(r_rd_en[n]), vt[i].rd_en);
      check($sformatf("t%0d_raddr", n), int'(r_raddr[n]), vt[i].raddr);
      check($sformatf("t%0d_valid", n), int'(r_valid[n]), vt[i].valid);
      if (vt[i].valid != 0)
        check($sformatf("t%0d_data", n), int'(r_data[n]), vt[i].data);
      check($sformatf("t%0d_eol", n), int'(r_eol[n]), vt[i].eol);
      check($sformatf("t%0d_eoh", n), int'(r_eoh[n]), vt[i].eoh);
      check($sformatf("t%0d_done", n), int'(r_done[n]), vt[i].done);
      check($sformatf("t%0d_busy", n), int'(r_busy[n]), vt[i].busy);
    end
    wait_empty(50);

    // ping-pong: half 1 announced first must wait its turn
    do_reset();
    push_half(0);
    push_half(1);
    pulse(2'b10);
    repeat (4) @(negedge clk);
    check("out_of_turn_wait", int'(busy), 0);
    repeat (4) @(posedge clk);
    pulse(2'b01);
    wait_done(2'b01, 1200);
    wait_done(2'b10, 1200);
    wait_empty(50);

    // random back-pressure, random pixel data
    for (int i = 0; i < 2 * HW; i++) mem[i] = 16'($urandom);
    rand_ready = 1'b1;
    push_half(0);
    push_half(1);
    pulse(2'b01);
    pulse(2'b10);
    wait_done(2'b01, 5000);
    wait_done(2'b10, 5000);
    wait_empty(50);
    rand_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);

    // overflow: half 0 announced in two adjacent cycles
    @(posedge clk); #1 half_ready = 2'b01;
    @(posedge clk); #1 half_ready = 2'b01;
    @(posedge clk); #1 half_ready = 2'b00;
    push_half(0);
    @(negedge clk);
    check("ovf_set", int'(ovf_err), 1);
    wait_done(2'b01, 1200);
    wait_empty(50);
    repeat (100) @(negedge clk);
    check("ovf_sticky", int'(ovf_err), 1);
    check("ovf_single_stream_busy", int'(busy), 0);
    check("ovf_no_extra_pix", int'(pix.pix_valid), 0);

    // reset in the middle of half 1
    push_half(1);
    @(negedge clk);
    p0 = popped;
    pulse(2'b10);
    n = 0;
    while (popped - p0 < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_pix500", int'(popped - p0 >= 500), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_half(0);
    pulse(2'b01);
    n = 0;
    while (!ram_rd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("restart_rd_en", int'(ram_rd_en), 1);
    check("restart_addr", int'(ram_raddr), 0);
    wait_done(2'b01, 1200);
    wait_empty(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
